// File: rtl/timer_device.sv
// Memory-mapped interval timer (TCNT/TLIM/TCTL/TSTAT) with prescaler, sticky ready/overrun and irq.
// Optional one-shot mode is compiled in when TIMER_ONESHOT_EN is defined.
module timer_device #(
    parameter int unsigned          DBITS     = 32,
    parameter int unsigned          PRESCALE  = 10000,
    parameter logic [DBITS-1:0]     BASE_ADDR = 32'hF0000020
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wrtEn,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] dIn,
    output logic [DBITS-1:0] dOut,
    output logic             sel,
    output logic             irq
);
    localparam logic [DBITS-1:0] PRE_MAX = DBITS'(PRESCALE - 1);

    logic [DBITS-1:0] tcnt_q, tcnt_d, tlim_q, tlim_d, pre_q, pre_d;
    logic             en_q, en_d, ie_q, ie_d, ready_q, ready_d, ovr_q, ovr_d;
    logic             oneshot, tick, wrap, wr;
    logic [DBITS-3:0] offw;
    logic [1:0]       word;
    logic             unused_ok;

`ifdef TIMER_ONESHOT_EN
    logic os_q, os_d;
    assign oneshot = os_q;
`else
    assign oneshot = 1'b0;
`endif

    // Word-granular decode: byte lane bits are ignored, window is four words from BASE_ADDR.
    assign offw      = addr[DBITS-1:2] - BASE_ADDR[DBITS-1:2];
    assign sel       = (offw[DBITS-3:2] == '0);
    assign word      = offw[1:0];
    assign wr        = wrtEn & sel;
    assign irq       = ready_q & ie_q;
    assign unused_ok = &{1'b0, addr[1:0]};

    always_comb begin
        dOut = '0;
        if (sel) begin
            case (word)
                2'd0: dOut = tcnt_q;
                2'd1: dOut = tlim_q;
                2'd2: dOut = DBITS'({ie_q, oneshot, en_q});
                2'd3: dOut = DBITS'({ovr_q, ready_q});
                default: dOut = '0;
            endcase
        end
    end

    always_comb begin
        pre_d = '0;
        tick  = 1'b0;
        if (en_q) begin
            if (pre_q == PRE_MAX) tick = 1'b1;
            else                  pre_d = pre_q + 1'b1;
        end
        wrap    = tick && (tcnt_q == tlim_q);
        tcnt_d  = tcnt_q;
        tlim_d  = tlim_q;
        en_d    = en_q;
        ie_d    = ie_q;
`ifdef TIMER_ONESHOT_EN
        os_d    = os_q;
`endif
        if (tick) tcnt_d = wrap ? '0 : tcnt_q + 1'b1;
        if (wrap && oneshot) en_d = 1'b0;
        // Status set on wrap always wins over a same-cycle W1C.
        ready_d = ready_q | wrap;
        ovr_d   = ovr_q | (wrap & ready_q);
        if (wr) begin
            case (word)
                2'd0: tcnt_d = dIn;
                2'd1: tlim_d = dIn;
                2'd2: begin
                    en_d = dIn[0];
                    ie_d = dIn[2];
`ifdef TIMER_ONESHOT_EN
                    os_d = dIn[1];
`endif
                end
                2'd3: begin
                    ready_d = (ready_q & ~dIn[0]) | wrap;
                    ovr_d   = (ovr_q & ~dIn[1]) | (wrap & ready_q);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt_q  <= '0;
            tlim_q  <= '0;
            pre_q   <= '0;
            en_q    <= 1'b0;
            ie_q    <= 1'b0;
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef TIMER_ONESHOT_EN
            os_q    <= 1'b0;
`endif
        end else begin
            tcnt_q  <= tcnt_d;
            tlim_q  <= tlim_d;
            pre_q   <= pre_d;
            en_q    <= en_d;
            ie_q    <= ie_d;
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
`ifdef TIMER_ONESHOT_EN
            os_q    <= os_d;
`endif
        end
    end
endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device with PRESCALE=4; one task per scenario.
module tb_timer_device;
    localparam logic [31:0] TCNT = 32'hF0000020, TLIM = 32'hF0000024,
                            TCTL = 32'hF0000028, TSTAT = 32'hF000002C;
    logic        clk = 1'b0, reset = 1'b0, wrtEn = 1'b0, sel, irq;
    logic [31:0] addr = '0, dIn = '0, dOut, d;
    int          tests = 0, fails = 0;

    timer_device #(.DBITS(32), .PRESCALE(4), .BASE_ADDR(32'hF0000020)) dut (
        .clk(clk), .reset(reset), .wrtEn(wrtEn), .addr(addr), .dIn(dIn),
        .dOut(dOut), .sel(sel), .irq(irq));

    always #5 clk = ~clk;

    // Called at a negedge; the store lands on the following posedge, returns at the next negedge.
    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        addr = a; dIn = v; wrtEn = 1'b1;
        @(negedge clk);
        wrtEn = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr = a; #1; v = dOut;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Restart the timer: the enabling store's edge is time zero, return point is j=0.
    task automatic setup(input logic [31:0] lim, input logic [31:0] ctl);
        wr(TCTL, 0); wr(TSTAT, 3); wr(TLIM, lim); wr(TCNT, 0); wr(TCTL, ctl);
    endtask

    task automatic test_reset;
        #1;
        rd(TCNT, d);  tests++; if (d !== 0) begin fails++; $display("FAIL rst_tcnt got=%h exp=0", d); end
        rd(TLIM, d);  tests++; if (d !== 0) begin fails++; $display("FAIL rst_tlim got=%h exp=0", d); end
        rd(TCTL, d);  tests++; if (d !== 0) begin fails++; $display("FAIL rst_tctl got=%h exp=0", d); end
        rd(TSTAT, d); tests++; if (d !== 0) begin fails++; $display("FAIL rst_tstat got=%h exp=0", d); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL rst_irq got=%b exp=0", irq); end
        @(negedge clk); reset = 1'b1; @(negedge clk);
    endtask

    task automatic test_periodic;
        setup(2, 5);
        cyc(3); rd(TCNT, d); tests++; if (d !== 0) begin fails++; $display("FAIL per_j3 got=%h exp=0", d); end
        cyc(1); rd(TCNT, d); tests++; if (d !== 1) begin fails++; $display("FAIL per_j4 got=%h exp=1", d); end
        cyc(4); rd(TCNT, d); tests++; if (d !== 2) begin fails++; $display("FAIL per_j8 got=%h exp=2", d); end
        cyc(3); rd(TSTAT, d); tests++; if (d !== 0 || irq !== 1'b0) begin fails++; $display("FAIL per_j11 stat=%h irq=%b exp 0/0", d, irq); end
        cyc(1); rd(TCNT, d); tests++; if (d !== 0) begin fails++; $display("FAIL per_wrap_cnt got=%h exp=0", d); end
        rd(TSTAT, d); tests++; if (d !== 1 || irq !== 1'b1) begin fails++; $display("FAIL per_ready stat=%h irq=%b exp 1/1", d, irq); end
        cyc(12); rd(TSTAT, d); tests++; if (d !== 3) begin fails++; $display("FAIL per_overrun got=%h exp=3", d); end
    endtask

    task automatic test_w1c;
        setup(2, 5);
        cyc(23); wr(TSTAT, 1);
        rd(TSTAT, d); tests++; if (d !== 3) begin fails++; $display("FAIL w1c_collide got=%h exp=3", d); end
        wr(TSTAT, 1);
        rd(TSTAT, d); tests++; if (d !== 2 || irq !== 1'b0) begin fails++; $display("FAIL w1c_ready stat=%h irq=%b exp 2/0", d, irq); end
        wr(TSTAT, 2);
        rd(TSTAT, d); tests++; if (d !== 0) begin fails++; $display("FAIL w1c_ovr got=%h exp=0", d); end
    endtask

    task automatic test_write_tick;
        setup(32'hFFFF, 1);
        cyc(7); wr(TCNT, 32'h100);
        rd(TCNT, d); tests++; if (d !== 32'h100) begin fails++; $display("FAIL wt_win got=%h exp=100", d); end
        cyc(3); rd(TCNT, d); tests++; if (d !== 32'h100) begin fails++; $display("FAIL wt_hold got=%h exp=100", d); end
        cyc(1); rd(TCNT, d); tests++; if (d !== 32'h101) begin fails++; $display("FAIL wt_next got=%h exp=101", d); end
    endtask

    task automatic test_decode;
        wr(TCTL, 0); wr(TCNT, 32'h55); wr(TLIM, 32'h1234);
        rd(32'hF0000014, d); tests++; if (d !== 0 || sel !== 1'b0) begin fails++; $display("FAIL dec_miss d=%h sel=%b exp 0/0", d, sel); end
        rd(32'hF0000026, d); tests++; if (d !== 32'h1234 || sel !== 1'b1) begin fails++; $display("FAIL dec_unal d=%h sel=%b exp 1234/1", d, sel); end
        wr(32'hF0000030, 32'hDEAD);
        wr(32'hF000001C, 32'hBEEF);
        rd(TCNT, d);  tests++; if (d !== 32'h55) begin fails++; $display("FAIL dec_tcnt got=%h exp=55", d); end
        rd(TLIM, d);  tests++; if (d !== 32'h1234) begin fails++; $display("FAIL dec_tlim got=%h exp=1234", d); end
        rd(TCTL, d);  tests++; if (d !== 0) begin fails++; $display("FAIL dec_tctl got=%h exp=0", d); end
    endtask

    task automatic test_oneshot;
        setup(1, 3);
`ifdef TIMER_ONESHOT_EN
        rd(TCTL, d); tests++; if (d !== 3) begin fails++; $display("FAIL os_ctl0 got=%h exp=3", d); end
        cyc(8);
        rd(TCTL, d); tests++; if (d !== 2) begin fails++; $display("FAIL os_ctl got=%h exp=2", d); end
        rd(TSTAT, d); tests++; if (d !== 1) begin fails++; $display("FAIL os_stat got=%h exp=1", d); end
        cyc(50); rd(TCNT, d); tests++; if (d !== 0) begin fails++; $display("FAIL os_hold got=%h exp=0", d); end
`else
        rd(TCTL, d); tests++; if (d !== 1) begin fails++; $display("FAIL os_ctl0 got=%h exp=1", d); end
        cyc(8);
        rd(TCTL, d); tests++; if (d !== 1) begin fails++; $display("FAIL os_ctl got=%h exp=1", d); end
        rd(TSTAT, d); tests++; if (d !== 1) begin fails++; $display("FAIL os_stat got=%h exp=1", d); end
        cyc(4); rd(TCNT, d); tests++; if (d !== 1) begin fails++; $display("FAIL os_cont got=%h exp=1", d); end
`endif
    endtask

    task automatic test_reset_mid;
        setup(5, 5);
        cyc(45);
        rd(TCNT, d); tests++; if (d !== 5 || irq !== 1'b1) begin fails++; $display("FAIL mid_pre cnt=%h irq=%b exp 5/1", d, irq); end
        reset = 1'b0;
        rd(TCNT, d);  tests++; if (d !== 0) begin fails++; $display("FAIL mid_tcnt got=%h exp=0", d); end
        rd(TCTL, d);  tests++; if (d !== 0) begin fails++; $display("FAIL mid_tctl got=%h exp=0", d); end
        rd(TSTAT, d); tests++; if (d !== 0 || irq !== 1'b0) begin fails++; $display("FAIL mid_stat stat=%h irq=%b exp 0/0", d, irq); end
        @(negedge clk); reset = 1'b1;
        cyc(100); rd(TCNT, d); tests++; if (d !== 0) begin fails++; $display("FAIL mid_after got=%h exp=0", d); end
    endtask

    initial begin
        test_reset;
        test_periodic;
        test_w1c;
        test_write_tick;
        test_decode;
        test_oneshot;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/timer_device.md
# timer_device

Memory-mapped interval timer that responds to the processor's data-memory accesses in the 0xF0000020–0xF000002F I/O window, alongside the existing KEY/SW/HEX/LEDR/LEDG devices. Loads read its registers combinationally in the memory stage; stores update them on the next clock edge. It divides the core clock by a prescaler, counts ticks up to a programmable limit, and raises a sticky ready flag and an optional interrupt line on each wrap.

## Interface
- DBITS, 32, data/address width
- PRESCALE, 10000, core-clock cycles per timer tick (≥1)
- BASE_ADDR, 32'hF0000020, address of TCNT; TLIM = +4, TCTL = +8, TSTAT = +C
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- wrtEn  in  1  store strobe from memory stage
- addr  in  DBITS  byte address from memory stage
- dIn  in  DBITS  store data
- dOut  out  DBITS  read data; 0 when `sel`=0
- sel  out  1  addr hits one of the four registers (word-aligned, addr[1:0] ignored)
- irq  out  1  TSTAT.ready & TCTL.ie

## Operation
- Registers:
  - TCNT: count, R/W.
  - TLIM: limit, R/W.
  - TCTL: bit0 `en`, bit1 `oneshot` (see Configuration), bit2 `ie`; other bits read 0.
  - TSTAT: bit0 `ready`, bit1 `overrun`; other bits read 0. Write 1 to clear, write 0 has no effect.
- Reset: TCNT=0, TLIM=0, TCTL=0, TSTAT=0, prescaler=0. Outputs: dOut=0 unless addr selects a register (value then 0), sel per addr, irq=0.
- Prescaler: increments while `en`=1. When it reaches PRESCALE-1, it returns to 0 and asserts an internal `tick` for one cycle. While `en`=0, the prescaler is held at 0.
- On tick:
  - If TCNT==TLIM: TCNT←0 (wrap), `overrun`←`ready`, `ready`←1.
  - Otherwise: TCNT←TCNT+1 (32-bit, no saturation).
- TLIM=0 wraps on every tick.
- If TCNT is written above TLIM, it counts up to 2^32−1, rolls to 0, then continues to TLIM.
- Simultaneous events:
  - CPU write to TCNT in a tick cycle: the write wins and the tick's TCNT update is dropped. The prescaler is unaffected.
  - W1C of `ready`/`overrun` in a wrap cycle: set wins, so the event is not lost.
  - Write to TCTL clearing `en` in a tick cycle: the tick still applies and the prescaler clears.
- Writes to unmapped offsets or with `sel`=0: ignored.
- Reset asserted mid-count: all state clears immediately (asynchronous); counting resumes from 0 after release only once `en` is written 1.

## Timing
- Read: combinational. dOut and sel are valid in the same cycle as addr, with no registered latency, matching the single-cycle memory-stage read.
- Write: takes effect at the rising edge in which wrtEn=1; the new value is visible on the next cycle's read.
- Tick period: exactly PRESCALE cycles after `en` is set. The first tick occurs PRESCALE cycles after the edge that wrote `en`=1.
- Wrap period with TLIM=L: (L+1)·PRESCALE cycles.
- `ready`, `overrun` and irq update at the edge following the wrap tick.

## Configuration
- TIMER_ONESHOT_EN defined:
  - TCTL.bit1 is writable.
  - On a wrap with `oneshot`=1, `en` also clears in the same edge.
  - TCNT holds at 0 and the prescaler clears.
- Undefined: TCTL.bit1 reads 0, writes to it are ignored, and the timer is always periodic.

## Test plan
- Reset: assert reset=0 mid-count with TCNT=5 → TCNT, TCTL, TSTAT read 0 immediately and irq=0. Release and wait 100 cycles → TCNT stays 0.
- Periodic wrap: PRESCALE=4, TLIM=2, TCTL=5 → TCNT goes 1,2,0 every 4 cycles; `ready`=1 and irq=1 twelve cycles after enable. A second wrap without clearing sets `overrun`=1.
- W1C collision: write TSTAT=1 in the cycle of a wrap → `ready` still reads 1 next cycle. A W1C in a quiet cycle → `ready` reads 0.
- Write-vs-tick: write TCNT=0x100 in a tick cycle → reads 0x100, not 0x101. The next tick gives 0x101 PRESCALE cycles later.
- Decode: read 0xF0000014 → sel=0, dOut=0. Read 0xF0000026 → sel=1, returns TLIM. Store to 0xF0000030 → no register changes.
- One-shot (TIMER_ONESHOT_EN): TCTL=3, TLIM=1 → after one wrap, TCTL reads 1·0b010=2 (en=0), TCNT stays 0 for 50 cycles. Without the macro, TCTL reads 1 and counting continues.
